// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory port arbiter.
//   arb_state_e : arbiter FSM states (idle / issue / read-latency wait)
//   req_id_t    : requester identifier, ReqCpu = 0, ReqDma = 1
//   other_id()  : returns the opposite requester, used for round-robin
package mem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StGrant = 2'd1,
      StWait  = 2'd2
   } arb_state_e;

   typedef logic req_id_t;

   localparam req_id_t ReqCpu = 1'b0;
   localparam req_id_t ReqDma = 1'b1;

   function automatic req_id_t other_id(input req_id_t id);
      return ~id;
   endfunction

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: combinational two-way picker between the CPU and DMA requesters.
//   i_cpu_req, i_dma_req : requests
//   i_last_winner        : requester that won the previous arbitration
//   i_dma_prio           : DMA burst priority (lock active and burst not exhausted)
//   o_winner             : chosen requester id
//   o_valid              : at least one request present
module arb_rr2
   import mem_arb_pkg::*;
(
   input  logic    i_cpu_req,
   input  logic    i_dma_req,
   input  req_id_t i_last_winner,
   input  logic    i_dma_prio,
   output req_id_t o_winner,
   output logic    o_valid
);

   always_comb begin
      o_valid  = i_cpu_req | i_dma_req;
      o_winner = ReqCpu;
      if (i_cpu_req && !i_dma_req) begin
         o_winner = ReqCpu;
      end else if (i_dma_req && !i_cpu_req) begin
         o_winner = ReqDma;
      end else if (i_cpu_req && i_dma_req) begin
         // Tie: locked DMA burst first, otherwise whoever lost last time.
         o_winner = i_dma_prio ? ReqDma : other_id(i_last_winner);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port unified memory between the CPU and a
// DMA/loader port. Each access is a registered, fixed-latency transaction:
// IDLE (arbitrate, register fields) -> GRANT (strobe memory, pulse gnt)
// -> WAIT (reads only, MEM_LAT cycles) -> IDLE.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   i_cpu_req/we/addr/wdata          : CPU request, held until o_cpu_gnt
//   o_cpu_gnt, o_cpu_rvalid          : CPU issue pulse, read-data-valid pulse
//   o_cpu_rdata                      : passthrough of i_mem_rdata
//   o_stall                          : holds the CPU controller while its access is pending
//   i_dma_req/we/addr/wdata, i_dma_lock, o_dma_gnt/rvalid/rdata : DMA equivalents
//   o_mem_re/we/addr/wdata, i_mem_rdata : memory port
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW        = 8,
   parameter int unsigned DW        = 8,
   parameter int unsigned MEM_LAT   = 1,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_cpu_req,
   input  logic          i_cpu_we,
   input  logic [AW-1:0] i_cpu_addr,
   input  logic [DW-1:0] i_cpu_wdata,
   output logic          o_cpu_gnt,
   output logic          o_cpu_rvalid,
   output logic [DW-1:0] o_cpu_rdata,
   output logic          o_stall,
   input  logic          i_dma_req,
   input  logic          i_dma_we,
   input  logic [AW-1:0] i_dma_addr,
   input  logic [DW-1:0] i_dma_wdata,
   input  logic          i_dma_lock,
   output logic          o_dma_gnt,
   output logic          o_dma_rvalid,
   output logic [DW-1:0] o_dma_rdata,
   output logic          o_mem_re,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata
);

   localparam int unsigned CntW   = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
   localparam int unsigned BurstW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

   arb_state_e        r_state;
   req_id_t           r_winner;
   logic              r_we;
   logic [AW-1:0]     r_addr;
   logic [DW-1:0]     r_wdata;
   req_id_t           r_last_winner;
   logic [BurstW-1:0] r_burst_cnt;
   logic [CntW-1:0]   r_cnt;

   arb_state_e        w_state_nxt;
   logic [BurstW-1:0] w_burst_nxt;
   logic [CntW-1:0]   w_cnt_nxt;
   logic              w_load;
   logic              w_lock_active;
   logic              w_burst_left;
   req_id_t           w_arb_winner;
   logic              w_arb_valid;

   assign w_lock_active = i_dma_lock & (r_last_winner == ReqDma);
   assign w_burst_left  = (r_burst_cnt < BurstW'(MAX_BURST));

   arb_rr2 u_arb_rr2 (
      .i_cpu_req    (i_cpu_req),
      .i_dma_req    (i_dma_req),
      .i_last_winner(r_last_winner),
      .i_dma_prio   (w_lock_active & w_burst_left),
      .o_winner     (w_arb_winner),
      .o_valid      (w_arb_valid)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_burst_nxt  = r_burst_cnt;
      w_cnt_nxt    = r_cnt;
      w_load       = 1'b0;
      o_cpu_gnt    = 1'b0;
      o_dma_gnt    = 1'b0;
      o_cpu_rvalid = 1'b0;
      o_dma_rvalid = 1'b0;
      o_mem_re     = 1'b0;
      o_mem_we     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (!i_dma_lock) begin
               w_burst_nxt = '0;
            end
            if (w_arb_valid) begin
               w_load      = 1'b1;
               w_state_nxt = StGrant;
               if (w_arb_winner == ReqCpu) begin
                  w_burst_nxt = '0;
               end else if (i_dma_lock && w_burst_left) begin
                  // Saturate so a lone locked DMA cannot wrap the counter.
                  w_burst_nxt = r_burst_cnt + BurstW'(1);
               end
            end
         end
         StGrant: begin
            o_mem_re  = ~r_we;
            o_mem_we  = r_we;
            o_cpu_gnt = (r_winner == ReqCpu);
            o_dma_gnt = (r_winner == ReqDma);
            if (r_we) begin
               w_state_nxt = StIdle;
            end else begin
               w_state_nxt = StWait;
               w_cnt_nxt   = CntW'(1);
            end
         end
         StWait: begin
            if (r_cnt == CntW'(MEM_LAT)) begin
               o_cpu_rvalid = (r_winner == ReqCpu);
               o_dma_rvalid = (r_winner == ReqDma);
               w_state_nxt  = StIdle;
               w_cnt_nxt    = '0;
            end else begin
               w_cnt_nxt = r_cnt + CntW'(1);
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= StIdle;
         r_winner      <= ReqCpu;
         r_we          <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_last_winner <= ReqDma;
         r_burst_cnt   <= '0;
         r_cnt         <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_burst_cnt <= w_burst_nxt;
         r_cnt       <= w_cnt_nxt;
         if (w_load) begin
            r_winner      <= w_arb_winner;
            r_last_winner <= w_arb_winner;
            r_we          <= (w_arb_winner == ReqDma) ? i_dma_we    : i_cpu_we;
            r_addr        <= (w_arb_winner == ReqDma) ? i_dma_addr  : i_cpu_addr;
            r_wdata       <= (w_arb_winner == ReqDma) ? i_dma_wdata : i_cpu_wdata;
         end
      end
   end

   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = r_wdata;
   assign o_cpu_rdata = i_mem_rdata;
   assign o_dma_rdata = i_mem_rdata;

   // Release the CPU in the cycle its write issues or its read data arrives.
   assign o_stall = i_cpu_req & ~(o_cpu_gnt & i_cpu_we) & ~o_cpu_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Default build (MEM_LAT=1, MAX_BURST=4)
   logic       rst;
   logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid, stall;
   logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic       dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
   logic [7:0] dma_addr, dma_wdata, dma_rdata;
   logic       mem_re, mem_we;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;

   // MEM_LAT=3 build
   logic       rst3;
   logic       cpu_req3, cpu_we3, cpu_gnt3, cpu_rvalid3, stall3;
   logic [7:0] cpu_addr3, cpu_wdata3, cpu_rdata3;
   logic       dma_req3, dma_we3, dma_lock3, dma_gnt3, dma_rvalid3;
   logic [7:0] dma_addr3, dma_wdata3, dma_rdata3;
   logic       mem_re3, mem_we3;
   logic [7:0] mem_addr3, mem_wdata3, mem_rdata3;

   mem_port_arbiter u_dut (
      .clk(clk), .rst(rst),
      .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
      .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata), .o_stall(stall),
      .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
      .i_dma_lock(dma_lock), .o_dma_gnt(dma_gnt), .o_dma_rvalid(dma_rvalid),
      .o_dma_rdata(dma_rdata), .o_mem_re(mem_re), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.MEM_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst3),
      .i_cpu_req(cpu_req3), .i_cpu_we(cpu_we3), .i_cpu_addr(cpu_addr3),
      .i_cpu_wdata(cpu_wdata3), .o_cpu_gnt(cpu_gnt3), .o_cpu_rvalid(cpu_rvalid3),
      .o_cpu_rdata(cpu_rdata3), .o_stall(stall3),
      .i_dma_req(dma_req3), .i_dma_we(dma_we3), .i_dma_addr(dma_addr3),
      .i_dma_wdata(dma_wdata3), .i_dma_lock(dma_lock3), .o_dma_gnt(dma_gnt3),
      .o_dma_rvalid(dma_rvalid3), .o_dma_rdata(dma_rdata3), .o_mem_re(mem_re3),
      .o_mem_we(mem_we3), .o_mem_addr(mem_addr3), .o_mem_wdata(mem_wdata3),
      .i_mem_rdata(mem_rdata3)
   );

   // Memory model, latency 1: data read in the issue cycle appears next cycle.
   logic [7:0] mem [256];
   logic [7:0] rd_q;
   always @(posedge clk) begin
      if (rst) begin
         mem[8'h10] <= 8'hA5;
         mem[8'hFF] <= 8'hC3;
      end else begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         if (mem_re) rd_q <= mem[mem_addr];
      end
   end
   assign mem_rdata  = rd_q;
   assign mem_rdata3 = 8'h77;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       dma;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   task automatic do_access(input vec_t v, input int idx);
      if (v.dma) begin
         dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
      end else begin
         cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
      end
      #1;
      check($sformatf("v%0d stall c0", idx), stall, !v.dma);
      cyc();
      check($sformatf("v%0d gnt c1", idx), v.dma ? dma_gnt : cpu_gnt, 1);
      check($sformatf("v%0d other gnt c1", idx), v.dma ? cpu_gnt : dma_gnt, 0);
      check($sformatf("v%0d mem_re c1", idx), mem_re, !v.we);
      check($sformatf("v%0d mem_we c1", idx), mem_we, v.we);
      check($sformatf("v%0d mem_addr c1", idx), mem_addr, v.addr);
      if (v.we) check($sformatf("v%0d mem_wdata c1", idx), mem_wdata, v.wdata);
      check($sformatf("v%0d stall c1", idx), stall, !v.dma && !v.we);
      if (v.we) begin
         cpu_req = 1'b0; dma_req = 1'b0;
         cyc();
         check($sformatf("v%0d idle strobes c2", idx), {cpu_gnt, dma_gnt, mem_re, mem_we}, 0);
      end else begin
         cyc();
         check($sformatf("v%0d rvalid c2", idx), v.dma ? dma_rvalid : cpu_rvalid, 1);
         check($sformatf("v%0d other rvalid c2", idx), v.dma ? cpu_rvalid : dma_rvalid, 0);
         check($sformatf("v%0d rdata c2", idx), v.dma ? dma_rdata : cpu_rdata, v.exp_rdata);
         check($sformatf("v%0d stall c2", idx), stall, 0);
         cpu_req = 1'b0; dma_req = 1'b0;
         cyc();
         check($sformatf("v%0d rvalid c3", idx), {cpu_rvalid, dma_rvalid}, 0);
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   // Collect grant order with both ports requesting writes continuously.
   task automatic collect_grants(input int want, output int n, output int order[8]);
      n = 0;
      for (int i = 0; i < 8; i++) order[i] = -1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'h01;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h31; dma_wdata = 8'h02;
      for (int c = 0; c < 40 && n < want; c++) begin
         cyc();
         if (cpu_gnt && dma_gnt) check("dual gnt", 2, 1);
         if (cpu_gnt) begin order[n] = 0; n++; end
         else if (dma_gnt) begin order[n] = 1; n++; end
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      cyc();
      cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      int order[8];
      int exp_alt[4];
      int exp_lock[6];

      vecs[0] = '{dma: 1'b0, we: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rdata: 8'hA5};
      vecs[1] = '{dma: 1'b1, we: 1'b1, addr: 8'h20, wdata: 8'h3C, exp_rdata: 8'h00};
      vecs[2] = '{dma: 1'b1, we: 1'b0, addr: 8'h20, wdata: 8'h00, exp_rdata: 8'h3C};
      vecs[3] = '{dma: 1'b0, we: 1'b1, addr: 8'h21, wdata: 8'h5A, exp_rdata: 8'h00};
      vecs[4] = '{dma: 1'b0, we: 1'b0, addr: 8'h21, wdata: 8'h00, exp_rdata: 8'h5A};
      vecs[5] = '{dma: 1'b1, we: 1'b0, addr: 8'hFF, wdata: 8'h00, exp_rdata: 8'hC3};
      exp_alt  = '{0, 1, 0, 1};
      exp_lock = '{1, 1, 1, 1, 0, 1};

      {cpu_req, cpu_we, cpu_addr, cpu_wdata} = '0;
      {dma_req, dma_we, dma_addr, dma_wdata, dma_lock} = '0;
      {cpu_req3, cpu_we3, cpu_addr3, cpu_wdata3} = '0;
      {dma_req3, dma_we3, dma_addr3, dma_wdata3, dma_lock3} = '0;
      rst  = 1'b1;
      rst3 = 1'b1;
      cyc();
      cyc();
      check("reset strobes", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_re, mem_we}, 0);
      check("reset mem_addr", mem_addr, 0);
      check("reset mem_wdata", mem_wdata, 0);
      check("reset stall", stall, 0);
      rst  = 1'b0;
      rst3 = 1'b0;
      cyc();
      check("post-reset idle strobes", {cpu_gnt, dma_gnt, mem_re, mem_we}, 0);

      for (int i = 0; i < 6; i++) do_access(vecs[i], i);

      // Simultaneous requests, no lock: alternate starting with CPU.
      reset_dut();
      collect_grants(4, n, order);
      check("alt grant count", n, 4);
      for (int i = 0; i < 4; i++) check($sformatf("alt order %0d", i), order[i], exp_alt[i]);

      // Locked DMA burst: MAX_BURST DMA grants, then the CPU, then DMA again.
      reset_dut();
      dma_lock = 1'b1;
      collect_grants(6, n, order);
      dma_lock = 1'b0;
      check("lock grant count", n, 6);
      for (int i = 0; i < 6; i++) check($sformatf("lock order %0d", i), order[i], exp_lock[i]);

      // MEM_LAT=3: DMA read latency and a CPU request arriving mid-access.
      dma_req3 = 1'b1; dma_we3 = 1'b0; dma_addr3 = 8'h40;
      cyc();
      check("l3 dma_gnt c1", dma_gnt3, 1);
      check("l3 mem_re c1", mem_re3, 1);
      dma_req3 = 1'b0;
      cyc();
      check("l3 rvalid c2", dma_rvalid3, 0);
      cpu_req3 = 1'b1; cpu_we3 = 1'b0; cpu_addr3 = 8'h41;
      #1;
      check("l3 stall c2", stall3, 1);
      cyc();
      check("l3 c3 quiet", {dma_rvalid3, cpu_gnt3}, 0);
      cyc();
      check("l3 dma_rvalid c4", dma_rvalid3, 1);
      check("l3 dma_rdata c4", dma_rdata3, 8'h77);
      check("l3 cpu_gnt c4", cpu_gnt3, 0);
      cyc();
      check("l3 c5 quiet", {dma_rvalid3, cpu_gnt3}, 0);
      cyc();
      check("l3 cpu_gnt c6", cpu_gnt3, 1);
      check("l3 mem_addr c6", mem_addr3, 8'h41);
      cyc();
      cyc();
      check("l3 cpu_rvalid c8", cpu_rvalid3, 0);
      cyc();
      check("l3 cpu_rvalid c9", cpu_rvalid3, 1);
      check("l3 stall c9", stall3, 0);
      cpu_req3 = 1'b0;
      cyc();

      // Reset during WAIT of a CPU read aborts it.
      cpu_req3 = 1'b1; cpu_we3 = 1'b0; cpu_addr3 = 8'h50;
      cyc();
      check("rw cpu_gnt c1", cpu_gnt3, 1);
      cyc();
      rst3 = 1'b1;
      cpu_req3 = 1'b0;
      #1;
      check("rw outputs in reset",
            {cpu_gnt3, cpu_rvalid3, dma_gnt3, dma_rvalid3, mem_re3, mem_we3, stall3}, 0);
      check("rw mem_addr in reset", mem_addr3, 0);
      check("rw mem_wdata in reset", mem_wdata3, 0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check($sformatf("rw held %0d", i), {cpu_rvalid3, mem_re3, mem_we3, cpu_gnt3}, 0);
      end
      rst3 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check($sformatf("rw after %0d", i), {cpu_rvalid3, mem_re3, mem_we3}, 0);
      end
      dma_req3 = 1'b1; dma_we3 = 1'b1; dma_addr3 = 8'h51; dma_wdata3 = 8'h99;
      cyc();
      check("rw new dma_gnt", dma_gnt3, 1);
      check("rw new mem_we", mem_we3, 1);
      check("rw new mem_addr", mem_addr3, 8'h51);
      check("rw new mem_wdata", mem_wdata3, 8'h99);
      dma_req3 = 1'b0;
      cyc();
      check("rw new idle", {dma_gnt3, mem_we3}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
